rvdebugmodule: RTL
==================

Name: rvdebugmodule

Overview:
Debug Module target for the DMI requests issued by the simulation DTM; sits directly downstream of it and consumes its debug_req/debug_resp channel. Decodes 7-bit DMI register accesses, implements a subset of the RISC-V debug spec v0.13 (dmcontrol, dmstatus, data0, system-bus access). Acts as a single-outstanding 32-bit system-bus master into the memory port, so the host front-end can load programs and read results.

Parameters:
ADDR_W, 32, system-bus address width
RESET_VECTOR_HALT, 0, reset value of dmcontrol.haltreq (0 = core runs after reset)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
debug_req_valid  input  1  DMI request valid
debug_req_ready  output  1  DMI request accepted
debug_req_bits_addr  input  7  DMI register address
debug_req_bits_op  input  2  0 nop, 1 read, 2 write, 3 reserved
debug_req_bits_data  input  32  write data
debug_resp_valid  output  1  DMI response valid
debug_resp_ready  input  1  DMI response consumed
debug_resp_bits_resp  output  2  0 success, 2 failed
debug_resp_bits_data  output  32  read data
mem_req_valid  output  1  bus request valid
mem_req_ready  input  1  bus request accepted
mem_req_addr  output  ADDR_W  word-aligned byte address
mem_req_wdata  output  32  write data
mem_req_wr  output  1  1 write, 0 read
mem_resp_valid  input  1  bus response (1-cycle pulse)
mem_resp_rdata  input  32  bus read data
core_halted  input  1  core halted status
dm_haltreq  output  1  halt request to core
dm_ndmreset  output  1  non-debug-module reset to core

Behaviour:
- Reset (sync, active-high): state IDLE; debug_req_ready=1, debug_resp_valid=0, resp/data=0; mem_req_valid=0; data0, sbaddress0, sbdata0, sberror, sbreadonaddr, sbreadondata, sbautoincrement=0; dmactive=0, ndmreset=0, haltreq=RESET_VECTOR_HALT. Reset mid-bus-transaction abandons it; late mem_resp_valid in IDLE is ignored.
- FSM: IDLE -> (req fire) DECODE -> SB_REQ (if bus access triggered) or RESP; SB_REQ -> SB_WAIT on mem_req_valid&&mem_req_ready; SB_WAIT -> RESP on mem_resp_valid; RESP -> IDLE on debug_resp_ready.
- debug_req_ready=1 only in IDLE; exactly one request outstanding. Response registered; earliest resp_valid 2 cycles after accept; held stable until resp_ready.
- mem_req_valid held with addr/wdata/wr stable until mem_req_ready.
- Registers (DMI addr):
  0x04 data0: RW scratch.
  0x10 dmcontrol: bit31 haltreq, bit1 ndmreset, bit0 dmactive RW; other bits read 0. Outputs driven from these bits.
  0x11 dmstatus RO: [3:0]=2, bit7=1 authenticated, bits9/8 allhalted/anyhalted=core_halted, bits11/10 allrunning/anyrunning=!core_halted.
  0x38 sbcs: [31:29]=1, bit21 sbbusy (1 while in SB_REQ/SB_WAIT), bit20 sbreadonaddr, [19:17]=2 RO, bit16 sbautoincrement, bit15 sbreadondata, [14:12] sberror W1C, [11:5]=32, bit2=1; others 0.
  0x39 sbaddress0: RW.
  0x3C sbdata0: RW.
  Other addresses: read 0, write ignored, resp 0.
- Bus triggers: write sbaddress0 with sbreadonaddr=1 -> read; write sbdata0 -> write of new data at sbaddress0; read sbdata0 with sbreadondata=1 -> returns current sbdata0, then read. Read data lands in sbdata0.
- Autoincrement: after any completed bus access, if sbautoincrement, sbaddress0 += 4 (wraps modulo 2^ADDR_W).
- Any trigger while sberror!=0 or sbaddress0[1:0]!=0: no bus access; misalignment sets sberror=3; DMI resp still 0.
- op=3: no side effects, resp=2. op=0: resp 0, data 0.
- DMI response for triggering accesses issued only after bus completes.

Decomposition:
- Package rvdebug_pkg: DMI op/resp encodings, DMI register address constants, sbcs bit positions, FSM state enum.
- Single module; no sub-module needed (bus master is FSM states).

Test Plan:
- Reset, read 0x11 with core_halted=0 -> resp 0, data 0x00000C82; read 0x38 -> 0x20040404.
- Write sbaddress0=0x100, write sbdata0=0xDEADBEEF -> one bus write addr 0x100 wdata 0xDEADBEEF; DMI resp only after mem_resp_valid.
- sbcs=0x00110000 (readonaddr+autoinc), write sbaddress0=0x100, memory returns 0x11,0x22; read sbdata0 with readondata -> bus reads 0x100 then 0x104, sbaddress0 ends 0x108.
- Write sbaddress0=0x102 with readonaddr -> no mem_req_valid, sbcs[14:12]=3; write sbcs bits14:12=3'b111 -> sberror=0.
- Hold mem_req_ready=0 5 cycles -> req signals stable, debug_req_ready=0, sbbusy=1; assert reset mid-wait -> IDLE next cycle, mem_req_valid=0.
- op=3 to 0x04 -> resp 2, data0 unchanged; write dmcontrol=0x80000003 -> dm_haltreq=1, dm_ndmreset=1.

Source files
------------

// File: rtl/rvdebug_pkg.sv
// Shared encodings for the debug module: DMI ops/responses, register map,
// sbcs field positions and the request-handling state machine.
package rvdebug_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_SBCS       = 7'h38;
  localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;

  localparam int SBCS_BUSY       = 21;
  localparam int SBCS_READONADDR = 20;
  localparam int SBCS_AUTOINC    = 16;
  localparam int SBCS_READONDATA = 15;
  localparam int SBCS_ERR_LSB    = 12;

  // sbversion=1, sbaccess=2 (32-bit), sbasize=32, sbaccess32 supported
  localparam logic [31:0] SBCS_FIXED = 32'h2004_0404;
  localparam logic [2:0]  SBERR_ALIGN = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SB_REQ,
    S_SB_WAIT,
    S_RESP
  } dm_state_e;

  function automatic logic [31:0] sbcs_word(input logic busy, input logic roa,
                                            input logic ai, input logic rod,
                                            input logic [2:0] err);
    logic [31:0] w;
    w = SBCS_FIXED;
    w[SBCS_BUSY]       = busy;
    w[SBCS_READONADDR] = roa;
    w[SBCS_AUTOINC]    = ai;
    w[SBCS_READONDATA] = rod;
    w[SBCS_ERR_LSB +: 3] = err;
    return w;
  endfunction

endpackage

// File: rtl/rvdebugmodule.sv
// DMI target: decodes one request at a time, answers from dmcontrol/dmstatus/
// data0/sbcs, and runs single-outstanding 32-bit system-bus accesses.
module rvdebugmodule
  import rvdebug_pkg::*;
#(
  parameter int ADDR_W            = 32,
  parameter bit RESET_VECTOR_HALT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debug_req_valid,
  output logic              debug_req_ready,
  input  logic [6:0]        debug_req_bits_addr,
  input  logic [1:0]        debug_req_bits_op,
  input  logic [31:0]       debug_req_bits_data,
  output logic              debug_resp_valid,
  input  logic              debug_resp_ready,
  output logic [1:0]        debug_resp_bits_resp,
  output logic [31:0]       debug_resp_bits_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic              mem_req_wr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  input  logic              core_halted,
  output logic              dm_haltreq,
  output logic              dm_ndmreset
);

  dm_state_e         state;
  logic [6:0]        req_addr;
  logic [1:0]        req_op;
  logic [31:0]       req_data;
  logic [31:0]       data0;
  logic [31:0]       sbdata0;
  logic [ADDR_W-1:0] sbaddress0;
  logic [2:0]        sberror;
  logic              sbreadonaddr, sbreadondata, sbautoincrement;
  logic              haltreq, ndmreset, dmactive;
  logic              sb_wr;
  logic              resp_valid_q, mem_req_valid_q;
  logic [1:0]        resp_q;
  logic [31:0]       resp_data_q;

  logic [31:0] rd_data;
  logic        sb_busy, wr_op, rd_op;
  logic        trig_addr, trig_wdata, trig_rdata, trig_any;
  logic [1:0]  trig_align;
  logic        sb_go, sb_misalign;

  assign sb_busy = (state == S_SB_REQ) || (state == S_SB_WAIT);
  assign wr_op   = (req_op == OP_WRITE);
  assign rd_op   = (req_op == OP_READ);

  always_comb begin
    rd_data = '0;
    case (req_addr)
      ADDR_DATA0:      rd_data = data0;
      ADDR_DMCONTROL:  rd_data = {haltreq, 29'd0, ndmreset, dmactive};
      ADDR_DMSTATUS:   rd_data = {20'd0, ~core_halted, ~core_halted, core_halted,
                                  core_halted, 1'b1, 3'd0, 4'd2};
      ADDR_SBCS:       rd_data = sbcs_word(sb_busy, sbreadonaddr, sbautoincrement,
                                           sbreadondata, sberror);
      ADDR_SBADDRESS0: rd_data = 32'(sbaddress0);
      ADDR_SBDATA0:    rd_data = sbdata0;
      default:         rd_data = '0;
    endcase
  end

  // An sbaddress0 write checks alignment of the address being written.
  assign trig_addr   = wr_op && (req_addr == ADDR_SBADDRESS0) && sbreadonaddr;
  assign trig_wdata  = wr_op && (req_addr == ADDR_SBDATA0);
  assign trig_rdata  = rd_op && (req_addr == ADDR_SBDATA0) && sbreadondata;
  assign trig_any    = trig_addr || trig_wdata || trig_rdata;
  assign trig_align  = trig_addr ? req_data[1:0] : sbaddress0[1:0];
  assign sb_go       = trig_any && (sberror == 3'd0) && (trig_align == 2'd0);
  assign sb_misalign = trig_any && (sberror == 3'd0) && (trig_align != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      req_addr        <= '0;
      req_op          <= OP_NOP;
      req_data        <= '0;
      data0           <= '0;
      sbdata0         <= '0;
      sbaddress0      <= '0;
      sberror         <= '0;
      sbreadonaddr    <= 1'b0;
      sbreadondata    <= 1'b0;
      sbautoincrement <= 1'b0;
      haltreq         <= RESET_VECTOR_HALT;
      ndmreset        <= 1'b0;
      dmactive        <= 1'b0;
      sb_wr           <= 1'b0;
      resp_valid_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      resp_q          <= RESP_OK;
      resp_data_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (debug_req_valid) begin
            req_addr <= debug_req_bits_addr;
            req_op   <= debug_req_bits_op;
            req_data <= debug_req_bits_data;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          resp_q      <= RESP_OK;
          resp_data_q <= '0;
          case (req_op)
            OP_NOP:  ;
            OP_READ: resp_data_q <= rd_data;
            OP_WRITE: begin
              case (req_addr)
                ADDR_DATA0: data0 <= req_data;
                ADDR_DMCONTROL: begin
                  haltreq  <= req_data[31];
                  ndmreset <= req_data[1];
                  dmactive <= req_data[0];
                end
                ADDR_SBCS: begin
                  sbreadonaddr    <= req_data[SBCS_READONADDR];
                  sbautoincrement <= req_data[SBCS_AUTOINC];
                  sbreadondata    <= req_data[SBCS_READONDATA];
                  sberror         <= sberror & ~req_data[SBCS_ERR_LSB +: 3];
                end
                ADDR_SBADDRESS0: sbaddress0 <= req_data[ADDR_W-1:0];
                ADDR_SBDATA0:    sbdata0    <= req_data;
                default: ;
              endcase
            end
            OP_RSVD: resp_q <= RESP_FAIL;
            default: ;
          endcase
          if (sb_misalign) sberror <= SBERR_ALIGN;
          if (sb_go) begin
            sb_wr           <= trig_wdata;
            mem_req_valid_q <= 1'b1;
            state           <= S_SB_REQ;
          end else begin
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_SB_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= S_SB_WAIT;
          end
        end
        S_SB_WAIT: begin
          if (mem_resp_valid) begin
            if (!sb_wr) sbdata0 <= mem_resp_rdata;
            if (sbautoincrement) sbaddress0 <= sbaddress0 + ADDR_W'(4);
            resp_valid_q <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (debug_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign debug_req_ready      = (state == S_IDLE);
  assign debug_resp_valid     = resp_valid_q;
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = resp_data_q;
  assign mem_req_valid        = mem_req_valid_q;
  assign mem_req_addr         = sbaddress0;
  assign mem_req_wdata        = sbdata0;
  assign mem_req_wr           = sb_wr;
  assign dm_haltreq           = haltreq;
  assign dm_ndmreset          = ndmreset;

endmodule
